// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the Amiga bus arbiter: FSM encoding, synchroniser depth and
// grant-acknowledge counter width.
package bus_arbiter_pkg;

  localparam int unsigned SyncDepth = 2;
  localparam int unsigned CntWidth  = 8;

  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t CntMax = '1;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDrain    = 3'd1,
    StGrant    = 3'd2,
    StWaitAck  = 3'd3,
    StDmaOwned = 3'd4,
    StRelease  = 3'd5
  } arb_state_e;

  // Saturating increment so a long wait can never wrap back under the timeout.
  function automatic cnt_t sat_inc(cnt_t v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter bundle: raw Amiga bus lines, engine handshake and configuration/status.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
();

  logic          mc_clk_falling;
  logic          nBR_IN;
  logic          nBGACK_IN;
  logic          nAS_IN;
  logic          engine_busy;
  logic          pi_req;
  logic [CntWidth-1:0] cfg_timeout;
  logic          timeout_clear;
  logic          pi_start;
  logic          nBG_OE;
  logic          dma_owned;
  logic          grant_timeout;

  modport slave (
    input  mc_clk_falling, nBR_IN, nBGACK_IN, nAS_IN, engine_busy, pi_req,
           cfg_timeout, timeout_clear,
    output pi_start, nBG_OE, dma_owned, grant_timeout
  );

  modport master (
    output mc_clk_falling, nBR_IN, nBGACK_IN, nAS_IN, engine_busy, pi_req,
           cfg_timeout, timeout_clear,
    input  pi_start, nBG_OE, dma_owned, grant_timeout
  );

endinterface

// File: rtl/sync_2ff.sv
// Flop-chain synchroniser for one asynchronous input; resets to ResetVal.
module sync_2ff
  import bus_arbiter_pkg::*;
#(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SyncDepth-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SyncDepth{ResetVal}};
    end else begin
      sync_q <= {sync_q[SyncDepth-2:0], d_i};
    end
  end

  assign q_o = sync_q[SyncDepth-1];

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the Amiga bus between external DMA masters and Pi-initiated transactions,
// stepping only on 7M falling-edge strobes and guaranteeing one Pi slot per DMA tenure.
module bus_arbiter
  import bus_arbiter_pkg::*;
(
  input logic          sys_clk,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  logic nbr_s, nbgack_s, nas_s;
  logic br, bgack, as_act, strobe;

  sync_2ff #(.ResetVal(1'b1)) u_sync_br (
    .clk_i(sys_clk), .rst_i(reset), .d_i(bus.nBR_IN), .q_o(nbr_s)
  );
  sync_2ff #(.ResetVal(1'b1)) u_sync_bgack (
    .clk_i(sys_clk), .rst_i(reset), .d_i(bus.nBGACK_IN), .q_o(nbgack_s)
  );
  sync_2ff #(.ResetVal(1'b1)) u_sync_as (
    .clk_i(sys_clk), .rst_i(reset), .d_i(bus.nAS_IN), .q_o(nas_s)
  );

  assign br     = ~nbr_s;
  assign bgack  = ~nbgack_s;
  assign as_act = ~nas_s;
  assign strobe = bus.mc_clk_falling;

  arb_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       pi_first_q, pi_first_d;
  logic       timeout_q, timeout_d;
  logic       nbg_oe_q, nbg_oe_d;
  logic       dma_q, dma_d;
  logic       set_timeout;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pi_first_q <= 1'b0;
      timeout_q  <= 1'b0;
      nbg_oe_q   <= 1'b0;
      dma_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pi_first_q <= pi_first_d;
      timeout_q  <= timeout_d;
      nbg_oe_q   <= nbg_oe_d;
      dma_q      <= dma_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pi_first_d  = pi_first_q;
    set_timeout = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The Pi slot is consumed once the engine starts, or forfeited if nothing is pending.
        if (bus.engine_busy || (strobe && !bus.pi_req)) begin
          pi_first_d = 1'b0;
        end
        if (strobe && br && !pi_first_q) begin
          state_d = bus.engine_busy ? StDrain : StGrant;
        end
      end
      StDrain: begin
        if (strobe) begin
          if (!bus.engine_busy) begin
            state_d = StGrant;
          end else if (!br) begin
            state_d = StIdle;
          end
        end
      end
      StGrant: begin
        cnt_d = '0;
        if (strobe) begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (strobe) begin
          if (bgack && !as_act) begin
            state_d = StDmaOwned;
          end else if (!br && !bgack) begin
            state_d = StIdle;
          end else begin
            cnt_d = sat_inc(cnt_q);
            if ((bus.cfg_timeout != '0) && (cnt_d >= bus.cfg_timeout)) begin
              set_timeout = 1'b1;
              state_d     = StIdle;
            end
          end
        end
      end
      StDmaOwned: begin
        if (strobe && !bgack) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        pi_first_d = 1'b1;
        if (strobe) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A fresh timeout outranks a simultaneous clear.
    if (set_timeout) begin
      timeout_d = 1'b1;
    end else if (bus.timeout_clear) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    nbg_oe_d = (state_d == StGrant) || (state_d == StWaitAck);
    dma_d    = (state_d == StDmaOwned);
  end

  assign bus.nBG_OE        = nbg_oe_q;
  assign bus.dma_owned     = dma_q;
  assign bus.grant_timeout = timeout_q;
  assign bus.pi_start      = !reset && (state_q == StIdle) && (!br || pi_first_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written corner
// sequences, then randomized stimulus against a behavioural model.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if bif ();

  bus_arbiter u_dut (
    .sys_clk(clk),
    .reset  (rst),
    .bus    (bif)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       nbr;
    bit       nbgack;
    bit       nas;
    bit       busy;
    bit       pireq;
    bit       tclr;
    bit [7:0] cfg;
    int       ncyc;
    bit       exp_nbg;
    bit       exp_dma;
    bit       exp_pist;
    bit       exp_gto;
  } vec_t;

  vec_t vecs[18];

  // Behavioural model state
  string m_state;
  bit    m_pf;
  bit    m_gto;
  int    m_waits;
  bit    m_br1, m_br2, m_bg1, m_bg2, m_as1, m_as2;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_idle();
    bif.mc_clk_falling = 1'b0;
    bif.nBR_IN         = 1'b1;
    bif.nBGACK_IN      = 1'b1;
    bif.nAS_IN         = 1'b1;
    bif.engine_busy    = 1'b0;
    bif.pi_req         = 1'b0;
    bif.cfg_timeout    = 8'd0;
    bif.timeout_clear  = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic model_reset();
    m_state = "IDLE";
    m_pf    = 1'b0;
    m_gto   = 1'b0;
    m_waits = 0;
    m_br1 = 1'b1; m_br2 = 1'b1;
    m_bg1 = 1'b1; m_bg2 = 1'b1;
    m_as1 = 1'b1; m_as2 = 1'b1;
  endtask

  // One system clock of the arbiter's rules, using the inputs as sampled at this edge.
  task automatic model_step();
    bit    br, bgack, asx, stb, busy, to, pf_n;
    string nxt;
    br    = !m_br2;
    bgack = !m_bg2;
    asx   = !m_as2;
    stb   = bif.mc_clk_falling;
    busy  = bif.engine_busy;
    nxt   = m_state;
    pf_n  = m_pf;
    to    = 1'b0;
    if (m_state == "IDLE") begin
      if (busy || (stb && !bif.pi_req)) pf_n = 1'b0;
      if (stb && br && !m_pf) nxt = busy ? "DRAIN" : "GRANT";
    end else if (m_state == "DRAIN") begin
      if (stb && !busy) nxt = "GRANT";
      else if (stb && !br) nxt = "IDLE";
    end else if (m_state == "GRANT") begin
      m_waits = 0;
      if (stb) nxt = "WAIT";
    end else if (m_state == "WAIT") begin
      if (stb) begin
        if (bgack && !asx) nxt = "DMA";
        else if (!br && !bgack) nxt = "IDLE";
        else begin
          m_waits++;
          if (bif.cfg_timeout != 0 && m_waits >= int'(bif.cfg_timeout)) begin
            to  = 1'b1;
            nxt = "IDLE";
          end
        end
      end
    end else if (m_state == "DMA") begin
      if (stb && !bgack) nxt = "REL";
    end else begin
      pf_n = 1'b1;
      if (stb) nxt = "IDLE";
    end
    if (to) m_gto = 1'b1;
    else if (bif.timeout_clear) m_gto = 1'b0;
    m_state = nxt;
    m_pf    = pf_n;
    m_br2 = m_br1; m_br1 = bif.nBR_IN;
    m_bg2 = m_bg1; m_bg1 = bif.nBGACK_IN;
    m_as2 = m_as1; m_as1 = bif.nAS_IN;
  endtask

  initial begin
    // nbr nbgack nas busy pireq tclr cfg ncyc | nbg dma pist gto
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 8'd0, 3, 0, 0, 1, 0};  // idle after reset
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 8'd0, 3, 1, 0, 0, 0};  // request -> GRANT
    vecs[2]  = '{0, 1, 1, 0, 0, 0, 8'd0, 1, 1, 0, 0, 0};  // WAIT_ACK
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 8'd0, 3, 0, 1, 0, 0};  // ack, AS idle -> DMA
    vecs[4]  = '{0, 1, 1, 0, 1, 0, 8'd0, 3, 0, 0, 0, 0};  // ack drops -> RELEASE
    vecs[5]  = '{0, 1, 1, 0, 1, 0, 8'd0, 1, 0, 0, 1, 0};  // IDLE with Pi slot
    vecs[6]  = '{0, 1, 1, 1, 1, 0, 8'd0, 1, 0, 0, 0, 0};  // engine starts, slot used
    vecs[7]  = '{0, 1, 1, 1, 1, 0, 8'd0, 1, 0, 0, 0, 0};  // -> DRAIN
    vecs[8]  = '{0, 1, 1, 1, 0, 0, 8'd0, 2, 0, 0, 0, 0};  // hold DRAIN
    vecs[9]  = '{0, 1, 1, 0, 0, 0, 8'd0, 1, 1, 0, 0, 0};  // engine done -> GRANT
    vecs[10] = '{1, 1, 1, 0, 0, 0, 8'd0, 1, 1, 0, 0, 0};  // -> WAIT_ACK
    vecs[11] = '{1, 1, 1, 0, 0, 0, 8'd0, 3, 0, 0, 1, 0};  // withdrawn -> IDLE
    vecs[12] = '{0, 1, 1, 0, 0, 0, 8'd4, 3, 1, 0, 0, 0};  // GRANT again
    vecs[13] = '{0, 1, 1, 0, 0, 0, 8'd4, 1, 1, 0, 0, 0};  // WAIT_ACK, count 0
    vecs[14] = '{0, 1, 1, 0, 0, 0, 8'd4, 3, 1, 0, 0, 0};  // count 3
    vecs[15] = '{0, 1, 1, 0, 0, 0, 8'd4, 1, 0, 0, 0, 1};  // count 4 -> timeout
    vecs[16] = '{1, 1, 1, 0, 0, 1, 8'd4, 1, 1, 0, 0, 0};  // clear, re-grant
    vecs[17] = '{1, 1, 1, 0, 0, 0, 8'd4, 3, 0, 0, 1, 0};  // withdrawn -> IDLE

    do_reset();
    check("rst_nbg", bif.nBG_OE, 1'b0);
    check("rst_dma", bif.dma_owned, 1'b0);
    check("rst_gto", bif.grant_timeout, 1'b0);

    for (int i = 0; i < 18; i++) begin
      bif.mc_clk_falling = 1'b1;
      bif.nBR_IN         = vecs[i].nbr;
      bif.nBGACK_IN      = vecs[i].nbgack;
      bif.nAS_IN         = vecs[i].nas;
      bif.engine_busy    = vecs[i].busy;
      bif.pi_req         = vecs[i].pireq;
      bif.timeout_clear  = vecs[i].tclr;
      bif.cfg_timeout    = vecs[i].cfg;
      tick(vecs[i].ncyc);
      check($sformatf("vec%0d_nbg", i), bif.nBG_OE, vecs[i].exp_nbg);
      check($sformatf("vec%0d_dma", i), bif.dma_owned, vecs[i].exp_dma);
      check($sformatf("vec%0d_pist", i), bif.pi_start, vecs[i].exp_pist);
      check($sformatf("vec%0d_gto", i), bif.grant_timeout, vecs[i].exp_gto);
    end

    // Reset pulse while DMA owns the bus
    do_reset();
    bif.mc_clk_falling = 1'b1;
    bif.nBR_IN = 1'b0;
    tick(4);
    bif.nBGACK_IN = 1'b0;
    tick(3);
    check("dmarst_owned", bif.dma_owned, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("dmarst_nbg", bif.nBG_OE, 1'b0);
    check("dmarst_dma", bif.dma_owned, 1'b0);
    check("dmarst_pist", bif.pi_start, 1'b0);
    check("dmarst_gto", bif.grant_timeout, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bif.nBR_IN = 1'b1;
    bif.nBGACK_IN = 1'b1;
    tick(1);
    check("dmarst_after_dma", bif.dma_owned, 1'b0);
    check("dmarst_after_pist", bif.pi_start, 1'b1);

    // Reset asserted mid-grant drops nBG_OE before any clock edge
    do_reset();
    bif.mc_clk_falling = 1'b1;
    bif.nBR_IN = 1'b0;
    tick(3);
    check("grantrst_on", bif.nBG_OE, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("grantrst_off", bif.nBG_OE, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // No strobe, no transition
    do_reset();
    bif.nBR_IN = 1'b0;
    tick(10);
    check("nostb_nbg", bif.nBG_OE, 1'b0);
    check("nostb_pist", bif.pi_start, 1'b0);
    bif.mc_clk_falling = 1'b1;
    tick(1);
    check("stb_nbg", bif.nBG_OE, 1'b1);
    bif.mc_clk_falling = 1'b0;
    tick(5);
    check("stb_hold_nbg", bif.nBG_OE, 1'b1);

    // Timeout coinciding with clear keeps the flag set
    do_reset();
    bif.cfg_timeout = 8'd2;
    bif.mc_clk_falling = 1'b1;
    bif.nBR_IN = 1'b0;
    tick(5);
    bif.timeout_clear = 1'b1;
    tick(1);
    check("toclr_same", bif.grant_timeout, 1'b1);
    check("toclr_nbg", bif.nBG_OE, 1'b0);
    bif.nBR_IN = 1'b1;
    tick(1);
    check("toclr_later", bif.grant_timeout, 1'b0);

    // Counter saturates rather than wrapping during a long disabled-timeout wait
    do_reset();
    bif.mc_clk_falling = 1'b1;
    bif.nBR_IN = 1'b0;
    tick(4);
    tick(300);
    check("sat_wait_nbg", bif.nBG_OE, 1'b1);
    bif.cfg_timeout = 8'd255;
    tick(1);
    check("sat_gto", bif.grant_timeout, 1'b1);
    check("sat_nbg", bif.nBG_OE, 1'b0);

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 4000 && bad < 40; i++) begin
      bif.mc_clk_falling = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bif.nBR_IN = ~bif.nBR_IN;
      if ($urandom_range(0, 11) == 0) bif.nBGACK_IN = ~bif.nBGACK_IN;
      if ($urandom_range(0, 3) == 0) bif.nAS_IN = ~bif.nAS_IN;
      if ($urandom_range(0, 7) == 0) bif.engine_busy = ~bif.engine_busy;
      if ($urandom_range(0, 9) == 0) bif.pi_req = ~bif.pi_req;
      bif.timeout_clear = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: bif.cfg_timeout = 8'd0;
          1: bif.cfg_timeout = 8'd2;
          2: bif.cfg_timeout = 8'd5;
          default: bif.cfg_timeout = 8'd20;
        endcase
      end
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("rnd%0d_nbg", i), bif.nBG_OE,
            (m_state == "GRANT") || (m_state == "WAIT"));
      check($sformatf("rnd%0d_dma", i), bif.dma_owned, m_state == "DMA");
      check($sformatf("rnd%0d_pist", i), bif.pi_start,
            (m_state == "IDLE") && (m_br2 || m_pf));
      check($sformatf("rnd%0d_gto", i), bif.grant_timeout, m_gto);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
